// File: rtl/trace_pkg.sv
// Shared types for the golden retire-trace checker: FSM states, failure
// causes, the retire record layout and the record comparator.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  typedef enum logic [2:0] {
    FF_NONE     = 3'd0,
    FF_PC       = 3'd1,
    FF_INSTR    = 3'd2,
    FF_WE       = 3'd3,
    FF_WADDR    = 3'd4,
    FF_OVERFLOW = 3'd5,
    FF_WDATA    = 3'd6
  } fail_field_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } retire_rec_t;

  // First differing field in priority order; r0 writes never compare wdata.
  function automatic fail_field_t compare_rec(retire_rec_t act, retire_rec_t exp);
    fail_field_t f;
    f = FF_NONE;
    if (act.pc != exp.pc)                                 f = FF_PC;
    else if (act.instr != exp.instr)                      f = FF_INSTR;
    else if (act.we != exp.we)                            f = FF_WE;
    else if (act.we && (act.waddr != exp.waddr))          f = FF_WADDR;
    else if (act.we && (act.waddr != 5'd0) &&
             (act.wdata != exp.wdata))                    f = FF_WDATA;
    return f;
  endfunction

  function automatic logic [31:0] field_expect(fail_field_t f, retire_rec_t exp);
    case (f)
      FF_PC:    return exp.pc;
      FF_INSTR: return exp.instr;
      FF_WE:    return {31'b0, exp.we};
      FF_WADDR: return {27'b0, exp.waddr};
      FF_WDATA: return exp.wdata;
      default:  return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Registered FIFO of retire records; a pushed entry is visible at the head
// no earlier than the following cycle. Push while full is accepted only with a pop.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  retire_rec_t data_i,
  input  logic        pop_i,
  output retire_rec_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en, rd_en;
  retire_rec_t mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
  assign head_o   = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/retire_trace_checker.sv
// Compares the core retire stream in order against a golden record stream,
// latching the first mismatch or FIFO overflow and reporting pass/fail.
module retire_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CHECK_LIMIT = 4096,
  parameter int CNT_W       = $clog2(CHECK_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_retire_valid,
  input  logic [31:0]      i_retire_pc,
  input  logic [31:0]      i_retire_instr,
  input  logic             i_retire_we,
  input  logic [4:0]       i_retire_waddr,
  input  logic [31:0]      i_retire_wdata,
  input  logic             i_gold_valid,
  output logic             o_gold_ready,
  input  logic [31:0]      i_gold_pc,
  input  logic [31:0]      i_gold_instr,
  input  logic             i_gold_we,
  input  logic [4:0]       i_gold_waddr,
  input  logic [31:0]      i_gold_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_mismatch,
  output logic [2:0]       o_fail_field,
  output logic [31:0]      o_fail_pc,
  output logic [31:0]      o_fail_expect,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CHECK_LIMIT);

  state_t      state_q, state_d;
  fail_field_t field_q, field_d;
  logic [31:0] fail_pc_q, fail_pc_d;
  logic [31:0] fail_exp_q, fail_exp_d;
  logic [CNT_W-1:0] count_q, count_d;

  retire_rec_t retire_rec, gold_rec, head_rec;
  fail_field_t cmp_field;
  logic        in_run, push, pop, full, empty;
  logic        match, mismatch, overflow;

  assign retire_rec = {i_retire_pc, i_retire_instr, i_retire_we, i_retire_waddr, i_retire_wdata};
  assign gold_rec   = {i_gold_pc, i_gold_instr, i_gold_we, i_gold_waddr, i_gold_wdata};

  assign in_run       = (state_q == ST_RUN);
  assign push         = in_run && i_retire_valid;
  assign o_gold_ready = in_run && !empty;
  assign pop          = o_gold_ready && i_gold_valid;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i (retire_rec),
    .pop_i  (pop),
    .head_o (head_rec),
    .full_o (full),
    .empty_o(empty)
  );

  assign cmp_field = compare_rec(head_rec, gold_rec);
  assign match     = pop && (cmp_field == FF_NONE);
  assign mismatch  = pop && (cmp_field != FF_NONE);
  // A same-cycle pop frees a slot, so only an unmatched push into a full FIFO loses data.
  assign overflow  = push && full && !pop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    fail_pc_d  = fail_pc_q;
    fail_exp_d = fail_exp_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: if (i_enable) state_d = ST_RUN;
      ST_RUN: begin
        if (match && (count_q != LIMIT)) count_d = count_q + CNT_W'(1);
        if (mismatch) begin
          state_d    = ST_FAIL;
          field_d    = cmp_field;
          fail_pc_d  = head_rec.pc;
          fail_exp_d = field_expect(cmp_field, gold_rec);
        end else if (count_d == LIMIT) begin
          state_d = ST_PASS;
        end else if (overflow) begin
          state_d    = ST_FAIL;
          field_d    = FF_OVERFLOW;
          fail_pc_d  = i_retire_pc;
          fail_exp_d = 32'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      field_q    <= FF_NONE;
      fail_pc_q  <= '0;
      fail_exp_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      fail_pc_q  <= fail_pc_d;
      fail_exp_q <= fail_exp_d;
      count_q    <= count_d;
    end
  end

  assign o_busy        = (state_q == ST_RUN);
  assign o_done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign o_mismatch    = (state_q == ST_FAIL);
  assign o_fail_field  = field_q;
  assign o_fail_pc     = fail_pc_q;
  assign o_fail_expect = fail_exp_q;
  assign o_count       = count_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
// Self-checking bench: three checker instances with different DEPTH/CHECK_LIMIT,
// one active at a time, checked every cycle against a queue-based reference model.
module tb_retire_trace_checker;
  import trace_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          sel;
  logic        rst_all, en, rv, gv, gv_en;
  retire_rec_t r_rec, g_rec;
  retire_rec_t gq[$];

  logic rst_a, rst_b, rst_c;
  assign rst_a = rst_all || (sel != 0);
  assign rst_b = rst_all || (sel != 1);
  assign rst_c = rst_all || (sel != 2);

  logic        ready_a, busy_a, done_a, mis_a;
  logic        ready_b, busy_b, done_b, mis_b;
  logic        ready_c, busy_c, done_c, mis_c;
  logic [2:0]  field_a, field_b, field_c;
  logic [31:0] fpc_a, fpc_b, fpc_c, fexp_a, fexp_b, fexp_c;
  logic [2:0]  cnt_a;
  logic [4:0]  cnt_b;
  logic [3:0]  cnt_c;

  retire_trace_checker #(.DEPTH(8), .CHECK_LIMIT(4)) dut_a (
    .clk(clk), .reset(rst_a), .i_enable(en), .i_retire_valid(rv),
    .i_retire_pc(r_rec.pc), .i_retire_instr(r_rec.instr), .i_retire_we(r_rec.we),
    .i_retire_waddr(r_rec.waddr), .i_retire_wdata(r_rec.wdata),
    .i_gold_valid(gv), .o_gold_ready(ready_a),
    .i_gold_pc(g_rec.pc), .i_gold_instr(g_rec.instr), .i_gold_we(g_rec.we),
    .i_gold_waddr(g_rec.waddr), .i_gold_wdata(g_rec.wdata),
    .o_busy(busy_a), .o_done(done_a), .o_mismatch(mis_a), .o_fail_field(field_a),
    .o_fail_pc(fpc_a), .o_fail_expect(fexp_a), .o_count(cnt_a));

  retire_trace_checker #(.DEPTH(8), .CHECK_LIMIT(16)) dut_b (
    .clk(clk), .reset(rst_b), .i_enable(en), .i_retire_valid(rv),
    .i_retire_pc(r_rec.pc), .i_retire_instr(r_rec.instr), .i_retire_we(r_rec.we),
    .i_retire_waddr(r_rec.waddr), .i_retire_wdata(r_rec.wdata),
    .i_gold_valid(gv), .o_gold_ready(ready_b),
    .i_gold_pc(g_rec.pc), .i_gold_instr(g_rec.instr), .i_gold_we(g_rec.we),
    .i_gold_waddr(g_rec.waddr), .i_gold_wdata(g_rec.wdata),
    .o_busy(busy_b), .o_done(done_b), .o_mismatch(mis_b), .o_fail_field(field_b),
    .o_fail_pc(fpc_b), .o_fail_expect(fexp_b), .o_count(cnt_b));

  retire_trace_checker #(.DEPTH(2), .CHECK_LIMIT(8)) dut_c (
    .clk(clk), .reset(rst_c), .i_enable(en), .i_retire_valid(rv),
    .i_retire_pc(r_rec.pc), .i_retire_instr(r_rec.instr), .i_retire_we(r_rec.we),
    .i_retire_waddr(r_rec.waddr), .i_retire_wdata(r_rec.wdata),
    .i_gold_valid(gv), .o_gold_ready(ready_c),
    .i_gold_pc(g_rec.pc), .i_gold_instr(g_rec.instr), .i_gold_we(g_rec.we),
    .i_gold_waddr(g_rec.waddr), .i_gold_wdata(g_rec.wdata),
    .o_busy(busy_c), .o_done(done_c), .o_mismatch(mis_c), .o_fail_field(field_c),
    .o_fail_pc(fpc_c), .o_fail_expect(fexp_c), .o_count(cnt_c));

  logic        o_ready, o_busy, o_done, o_mis;
  logic [31:0] o_field, o_fpc, o_fexp, o_cnt;

  always_comb begin
    o_ready = ready_a; o_busy = busy_a; o_done = done_a; o_mis = mis_a;
    o_field = 32'(field_a); o_fpc = fpc_a; o_fexp = fexp_a; o_cnt = 32'(cnt_a);
    if (sel == 1) begin
      o_ready = ready_b; o_busy = busy_b; o_done = done_b; o_mis = mis_b;
      o_field = 32'(field_b); o_fpc = fpc_b; o_fexp = fexp_b; o_cnt = 32'(cnt_b);
    end else if (sel == 2) begin
      o_ready = ready_c; o_busy = busy_c; o_done = done_c; o_mis = mis_c;
      o_field = 32'(field_c); o_fpc = fpc_c; o_fexp = fexp_c; o_cnt = 32'(cnt_c);
    end
  end

  // Reference model: 0 idle, 1 checking, 2 passed, 3 failed.
  int          m_st, m_cnt, m_field, m_dep, m_lim;
  logic [31:0] m_fpc, m_fexp;
  retire_rec_t mq[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_step(output bit hs);
    bit full_before, ovf;
    int cause;
    logic [31:0] cexp;
    retire_rec_t h;
    hs = 0; cause = 0; cexp = 0;
    if (rst_all) begin
      m_st = 0; mq.delete(); m_cnt = 0; m_field = 0; m_fpc = 0; m_fexp = 0;
      return;
    end
    if (m_st == 0) begin
      if (en) m_st = 1;
      return;
    end
    if (m_st != 1) return;
    full_before = (mq.size() == m_dep);
    hs = (mq.size() > 0) && gv;
    if (hs) begin
      h = mq.pop_front();
      if (h.pc != g_rec.pc) begin cause = 1; cexp = g_rec.pc; end
      else if (h.instr != g_rec.instr) begin cause = 2; cexp = g_rec.instr; end
      else if (h.we != g_rec.we) begin cause = 3; cexp = 32'(g_rec.we); end
      else if (h.we && h.waddr != g_rec.waddr) begin cause = 4; cexp = 32'(g_rec.waddr); end
      else if (h.we && h.waddr != 0 && h.wdata != g_rec.wdata) begin cause = 6; cexp = g_rec.wdata; end
    end
    ovf = rv && full_before && !hs;
    if (rv && !ovf) mq.push_back(r_rec);
    if (cause != 0) begin
      m_st = 3; m_field = cause; m_fpc = h.pc; m_fexp = cexp;
    end else begin
      if (hs && m_cnt < m_lim) m_cnt++;
      if (m_cnt == m_lim) m_st = 2;
      else if (ovf) begin m_st = 3; m_field = 5; m_fpc = r_rec.pc; m_fexp = 0; end
    end
  endtask

  function automatic retire_rec_t rand_rec();
    retire_rec_t r;
    r.pc = $urandom(); r.instr = $urandom(); r.we = 1'($urandom_range(0, 1));
    r.waddr = 5'($urandom_range(0, 31)); r.wdata = $urandom();
    return r;
  endfunction

  function automatic retire_rec_t mk(int k, logic [31:0] wdata);
    retire_rec_t r;
    r.pc = 32'h0040_0000 + 32'(4 * k); r.instr = 32'h2408_0001 + 32'(k);
    r.we = 1'b1; r.waddr = 5'd8; r.wdata = wdata;
    return r;
  endfunction

  task automatic drive_gold();
    gv = gv_en && (gq.size() > 0);
    g_rec = (gq.size() > 0) ? gq[0] : rand_rec();
  endtask

  task automatic tick();
    bit hs;
    @(negedge clk);
    check("gold_ready", 32'(o_ready), 32'(m_st == 1 && mq.size() > 0));
    model_step(hs);
    @(posedge clk);
    #1;
    if (hs) void'(gq.pop_front());
    drive_gold();
    if (!rv) r_rec = rand_rec();
    check("busy", 32'(o_busy), 32'(m_st == 1));
    check("done", 32'(o_done), 32'(m_st >= 2));
    check("mismatch", 32'(o_mis), 32'(m_st == 3));
    check("fail_field", o_field, 32'(m_field));
    check("fail_pc", o_fpc, m_fpc);
    check("fail_expect", o_fexp, m_fexp);
    check("count", o_cnt, 32'(m_cnt));
  endtask

  task automatic select(int k);
    sel = k;
    m_dep = (k == 2) ? 2 : 8;
    m_lim = (k == 0) ? 4 : (k == 1) ? 16 : 8;
    rst_all = 1; en = 0; rv = 0; gv_en = 0; gq.delete(); drive_gold();
    tick();
    rst_all = 0;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_count", o_cnt, 0);
    check("rst_ready", 32'(o_ready), 0);
  endtask

  task automatic start();
    en = 1; tick(); en = 0;
  endtask

  task automatic retire(retire_rec_t rec);
    rv = 1; r_rec = rec; tick(); rv = 0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (!o_done && n < budget) begin tick(); n++; end
    check("done_within_budget", 32'(o_done), 1);
  endtask

  initial begin
    sel = 0; rst_all = 1; en = 0; rv = 0; gv_en = 0; r_rec = '0; g_rec = '0; gv = 0;

    // Happy path, CHECK_LIMIT=4; a retire before enable must be dropped.
    select(0);
    retire(mk(9, 32'd9));
    start();
    for (int k = 0; k < 4; k++) gq.push_back(mk(k, 32'(k)));
    gv_en = 1; drive_gold();
    for (int k = 0; k < 4; k++) retire(mk(k, 32'(k)));
    wait_done(20);
    check("happy_count", o_cnt, 4);
    check("happy_mismatch", 32'(o_mis), 0);
    check("happy_field", o_field, 0);

    // Golden stall: 5 retires over 6 cycles with golden invalid, then drain.
    select(1);
    start();
    for (int k = 0; k < 5; k++) gq.push_back(mk(k, 32'(k)));
    drive_gold();
    for (int k = 0; k < 6; k++) begin
      if (k < 5) retire(mk(k, 32'(k))); else tick();
    end
    check("stall_no_ovf", 32'(o_mis), 0);
    gv_en = 1; drive_gold();
    repeat (5) tick();
    check("stall_count", o_cnt, 5);
    check("stall_busy", 32'(o_busy), 1);

    // wdata mismatch on the third record.
    select(0);
    start();
    for (int k = 0; k < 4; k++) gq.push_back(mk(k, (k == 2) ? 32'h6 : 32'(k)));
    gv_en = 1; drive_gold();
    for (int k = 0; k < 4; k++) retire(mk(k, (k == 2) ? 32'h5 : 32'(k)));
    wait_done(20);
    repeat (3) tick();
    check("wdata_field", o_field, 6);
    check("wdata_fpc", o_fpc, 32'h0040_0008);
    check("wdata_fexp", o_fexp, 32'h6);
    check("wdata_count", o_cnt, 2);

    // r0 write: wdata differs but is ignored.
    select(1);
    start();
    r_rec = mk(0, 32'h0); r_rec.waddr = 5'd0;
    gq.push_back(r_rec); gv_en = 1; drive_gold();
    r_rec.wdata = 32'h1234;
    retire(r_rec);
    repeat (3) tick();
    check("r0_count", o_cnt, 1);
    check("r0_mismatch", 32'(o_mis), 0);

    // Overflow with DEPTH=2: third consecutive push fails.
    select(2);
    start();
    for (int k = 0; k < 3; k++) retire(mk(k, 32'(k)));
    check("ovf_mismatch", 32'(o_mis), 1);
    check("ovf_field", o_field, 5);
    check("ovf_fpc", o_fpc, 32'h0040_0008);
    check("ovf_fexp", o_fexp, 0);

    // Reset mid-run with three queued entries, then restart.
    select(1);
    start();
    for (int k = 0; k < 3; k++) retire(mk(k, 32'(k)));
    rst_all = 1; gq.delete(); drive_gold();
    tick();
    rst_all = 0;
    check("midrst_busy", 32'(o_busy), 0);
    check("midrst_ready", 32'(o_ready), 0);
    check("midrst_done", 32'(o_done), 0);
    start();
    check("restart_count", o_cnt, 0);
    check("restart_busy", 32'(o_busy), 1);
    for (int k = 0; k < 2; k++) gq.push_back(mk(k + 20, 32'(k)));
    gv_en = 1; drive_gold();
    for (int k = 0; k < 2; k++) retire(mk(k + 20, 32'(k)));
    repeat (2) tick();
    check("restart_count2", o_cnt, 2);

    // Randomized runs on the deep and shallow instances with occasional corruption.
    for (int run = 0; run < 8; run++) begin
      retire_rec_t recs[$];
      int ptr = 0;
      select((run % 2 == 0) ? 1 : 2);
      start();
      for (int i = 0; i < 20; i++) begin
        retire_rec_t r = rand_rec();
        recs.push_back(r);
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 4))
            0: r.pc ^= 32'h4;
            1: r.instr ^= 32'h100;
            2: r.we ^= 1'b1;
            3: r.waddr ^= 5'($urandom_range(1, 31));
            default: r.wdata ^= ($urandom() | 32'h1);
          endcase
        end
        gq.push_back(r);
      end
      for (int c = 0; c < 80; c++) begin
        gv_en = ($urandom_range(0, 2) != 0);
        drive_gold();
        rv = ($urandom_range(0, 1) == 1) && (ptr < 20);
        if (rv) begin r_rec = recs[ptr]; ptr++; end
        tick();
        rv = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
